// File: rtl/session_timer_if.sv
// Control and status bundle between the ATM FSM (master) and the session timer (slave).
interface session_timer_if #(
  parameter int unsigned SEC_W = 8
);
  logic             start;
  logic             stop;
  logic             kick;
  logic             ack;
  logic [SEC_W-1:0] remaining;
  logic             busy;
  logic             warn;
  logic             timeout;
  logic             expired;

  modport master (
    output start, stop, kick, ack,
    input  remaining, busy, warn, timeout, expired
  );

  modport slave (
    input  start, stop, kick, ack,
    output remaining, busy, warn, timeout, expired
  );
endinterface

// File: rtl/session_timer.sv
// Inactivity/session timer: counts whole seconds from a prescaler, warns near the end,
// and flags expiry with a one-cycle pulse plus a sticky level cleared by ack.
module session_timer #(
  parameter int unsigned CLK_FREQ    = 1000000,
  parameter int unsigned TIMEOUT_SEC = 30,
  parameter int unsigned WARN_SEC    = 10,
  parameter int unsigned SEC_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  session_timer_if.slave        tmr
);

  localparam int unsigned PreW = $clog2(CLK_FREQ);
  localparam logic [PreW-1:0]  PreMax  = PreW'(CLK_FREQ - 1);
  localparam logic [SEC_W-1:0] Reload  = SEC_W'(TIMEOUT_SEC);
  localparam logic [SEC_W-1:0] WarnVal = SEC_W'(WARN_SEC);

  typedef enum logic [1:0] {StIdle, StRun, StWarn, StExpired} state_e;

  state_e           state_q, state_d;
  logic [PreW-1:0]  pre_q, pre_d;
  logic [SEC_W-1:0] rem_q, rem_d;
  logic             timeout_q, timeout_d;

  logic             counting;
  logic [SEC_W-1:0] rem_dec;

  assign counting = (state_q == StRun) || (state_q == StWarn);
  assign rem_dec  = rem_q - SEC_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pre_q     <= '0;
      rem_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      rem_q     <= rem_d;
      timeout_q <= timeout_d;
    end
  end

  // Priority: stop > start > kick > ack > tick.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    rem_d   = rem_q;
    if (tmr.stop) begin
      state_d = StIdle;
      pre_d   = '0;
      rem_d   = '0;
    end else if (tmr.start) begin
      state_d = StRun;
      pre_d   = '0;
      rem_d   = Reload;
    end else begin
      unique case (state_q)
        StIdle: begin
          pre_d = '0;
          rem_d = '0;
        end
        StRun, StWarn: begin
          if (tmr.kick) begin
            state_d = StRun;
            pre_d   = '0;
            rem_d   = Reload;
          end else if (pre_q == PreMax) begin
            pre_d = '0;
            rem_d = rem_dec;
            // Expiry wins over warn if both thresholds coincide.
            if (rem_dec == '0) begin
              state_d = StExpired;
            end else if (state_q == StRun && WARN_SEC != 0 && rem_dec == WarnVal) begin
              state_d = StWarn;
            end
          end else begin
            pre_d = pre_q + PreW'(1);
          end
        end
        StExpired: begin
          pre_d = '0;
          rem_d = '0;
          if (tmr.ack) begin
            state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
          pre_d   = '0;
          rem_d   = '0;
        end
      endcase
    end
  end

  assign timeout_d = (state_d == StExpired) && (state_q != StExpired);

  assign tmr.remaining = rem_q;
  assign tmr.busy      = counting;
  assign tmr.warn      = (state_q == StWarn);
  assign tmr.expired   = (state_q == StExpired);
  assign tmr.timeout   = timeout_q;

endmodule

// File: tb/tb_session_timer.sv
// Directed bench for session_timer: CLK_FREQ=4, TIMEOUT_SEC=3, WARN_SEC=1 on the main
// instance, plus a TIMEOUT_SEC=2, WARN_SEC=0 instance for the warning-disabled case.
module tb_session_timer;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  session_timer_if #(.SEC_W(8)) u_if ();
  session_timer_if #(.SEC_W(8)) u_if2 ();

  session_timer #(
    .CLK_FREQ(4), .TIMEOUT_SEC(3), .WARN_SEC(1), .SEC_W(8)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tmr   (u_if)
  );

  session_timer #(
    .CLK_FREQ(4), .TIMEOUT_SEC(2), .WARN_SEC(0), .SEC_W(8)
  ) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .tmr   (u_if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Pulse start for one edge; returns just after that edge (edge 0).
  task automatic do_start();
    u_if.start = 1'b1;
    step();
    u_if.start = 1'b0;
  endtask

  task automatic do_stop();
    u_if.stop = 1'b1;
    step();
    u_if.stop = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({u_if.busy, u_if.warn, u_if.timeout, u_if.expired} !== 4'b0000 ||
        u_if.remaining !== 8'd0) begin
      bad++;
      $display("FAIL reset_async: busy/warn/timeout/expired=%b rem=%0d, want 0000 rem=0",
               {u_if.busy, u_if.warn, u_if.timeout, u_if.expired}, u_if.remaining);
    end
    steps(2);
    #3 rst_n = 1'b1;
    step();
    total++;
    if (u_if.busy !== 1'b0 || u_if.remaining !== 8'd0) begin
      bad++;
      $display("FAIL reset_idle: busy=%b rem=%0d, want 0 0", u_if.busy, u_if.remaining);
    end
  endtask

  task automatic test_nominal();
    do_start();
    total++;
    if (u_if.busy !== 1'b1 || u_if.remaining !== 8'd3 || u_if.warn !== 1'b0) begin
      bad++;
      $display("FAIL nom_start: busy=%b rem=%0d warn=%b, want 1 3 0",
               u_if.busy, u_if.remaining, u_if.warn);
    end
    steps(3);
    total++;
    if (u_if.remaining !== 8'd3) begin
      bad++;
      $display("FAIL nom_edge3: rem=%0d, want 3", u_if.remaining);
    end
    step();
    total++;
    if (u_if.remaining !== 8'd2 || u_if.warn !== 1'b0) begin
      bad++;
      $display("FAIL nom_edge4: rem=%0d warn=%b, want 2 0", u_if.remaining, u_if.warn);
    end
    steps(4);
    total++;
    if (u_if.remaining !== 8'd1 || u_if.warn !== 1'b1 || u_if.busy !== 1'b1) begin
      bad++;
      $display("FAIL nom_edge8: rem=%0d warn=%b busy=%b, want 1 1 1",
               u_if.remaining, u_if.warn, u_if.busy);
    end
    steps(3);
    total++;
    if (u_if.timeout !== 1'b0 || u_if.expired !== 1'b0 || u_if.busy !== 1'b1) begin
      bad++;
      $display("FAIL nom_edge11: timeout=%b expired=%b busy=%b, want 0 0 1",
               u_if.timeout, u_if.expired, u_if.busy);
    end
    step();
    total++;
    if ({u_if.timeout, u_if.expired, u_if.busy, u_if.warn} !== 4'b1100 ||
        u_if.remaining !== 8'd0) begin
      bad++;
      $display("FAIL nom_edge12: timeout/expired/busy/warn=%b rem=%0d, want 1100 0",
               {u_if.timeout, u_if.expired, u_if.busy, u_if.warn}, u_if.remaining);
    end
    step();
    total++;
    if (u_if.timeout !== 1'b0 || u_if.expired !== 1'b1 || u_if.busy !== 1'b0) begin
      bad++;
      $display("FAIL nom_edge13: timeout=%b expired=%b busy=%b, want 0 1 0",
               u_if.timeout, u_if.expired, u_if.busy);
    end
    u_if.ack = 1'b1;
    step();
    u_if.ack = 1'b0;
    total++;
    if (u_if.expired !== 1'b0 || u_if.busy !== 1'b0) begin
      bad++;
      $display("FAIL nom_ack: expired=%b busy=%b, want 0 0", u_if.expired, u_if.busy);
    end
  endtask

  task automatic test_kick();
    do_start();
    steps(9);
    total++;
    if (u_if.warn !== 1'b1) begin
      bad++;
      $display("FAIL kick_prewarn: warn=%b, want 1", u_if.warn);
    end
    u_if.kick = 1'b1;
    step();
    u_if.kick = 1'b0;
    total++;
    if (u_if.warn !== 1'b0 || u_if.remaining !== 8'd3 || u_if.busy !== 1'b1) begin
      bad++;
      $display("FAIL kick_edge10: warn=%b rem=%0d busy=%b, want 0 3 1",
               u_if.warn, u_if.remaining, u_if.busy);
    end
    steps(11);
    total++;
    if (u_if.timeout !== 1'b0 || u_if.remaining !== 8'd1) begin
      bad++;
      $display("FAIL kick_edge21: timeout=%b rem=%0d, want 0 1", u_if.timeout, u_if.remaining);
    end
    step();
    total++;
    if (u_if.timeout !== 1'b1 || u_if.expired !== 1'b1) begin
      bad++;
      $display("FAIL kick_edge22: timeout=%b expired=%b, want 1 1", u_if.timeout, u_if.expired);
    end
    u_if.ack = 1'b1;
    step();
    u_if.ack = 1'b0;
    // Kick landing on a tick edge reloads instead of decrementing.
    do_start();
    steps(3);
    u_if.kick = 1'b1;
    step();
    u_if.kick = 1'b0;
    total++;
    if (u_if.remaining !== 8'd3) begin
      bad++;
      $display("FAIL kick_on_tick: rem=%0d, want 3", u_if.remaining);
    end
    steps(4);
    total++;
    if (u_if.remaining !== 8'd2) begin
      bad++;
      $display("FAIL kick_on_tick_next: rem=%0d, want 2", u_if.remaining);
    end
    do_stop();
  endtask

  task automatic test_ignored();
    do_start();
    steps(12);
    u_if.kick = 1'b1;
    step();
    u_if.kick = 1'b0;
    total++;
    if (u_if.expired !== 1'b1 || u_if.busy !== 1'b0 || u_if.remaining !== 8'd0 ||
        u_if.timeout !== 1'b0) begin
      bad++;
      $display("FAIL kick_in_expired: expired=%b busy=%b rem=%0d timeout=%b, want 1 0 0 0",
               u_if.expired, u_if.busy, u_if.remaining, u_if.timeout);
    end
    u_if.ack = 1'b1;
    step();
    u_if.ack = 1'b0;
    total++;
    if (u_if.expired !== 1'b0 || u_if.busy !== 1'b0) begin
      bad++;
      $display("FAIL ack_expired: expired=%b busy=%b, want 0 0", u_if.expired, u_if.busy);
    end
    u_if.kick = 1'b1;
    step();
    u_if.kick = 1'b0;
    total++;
    if (u_if.busy !== 1'b0 || u_if.remaining !== 8'd0) begin
      bad++;
      $display("FAIL kick_in_idle: busy=%b rem=%0d, want 0 0", u_if.busy, u_if.remaining);
    end
    do_start();
    steps(2);
    u_if.ack = 1'b1;
    step();
    u_if.ack = 1'b0;
    step();
    total++;
    if (u_if.busy !== 1'b1 || u_if.remaining !== 8'd2 || u_if.expired !== 1'b0) begin
      bad++;
      $display("FAIL ack_in_run: busy=%b rem=%0d expired=%b, want 1 2 0",
               u_if.busy, u_if.remaining, u_if.expired);
    end
    do_stop();
    // Ack coincident with the timeout pulse cycle is honoured.
    do_start();
    steps(12);
    u_if.ack = 1'b1;
    step();
    u_if.ack = 1'b0;
    total++;
    if (u_if.expired !== 1'b0 || u_if.timeout !== 1'b0) begin
      bad++;
      $display("FAIL ack_on_timeout: expired=%b timeout=%b, want 0 0",
               u_if.expired, u_if.timeout);
    end
  endtask

  task automatic test_stop();
    do_start();
    steps(4);
    u_if.stop = 1'b1;
    step();
    u_if.stop = 1'b0;
    total++;
    if ({u_if.busy, u_if.warn, u_if.timeout, u_if.expired} !== 4'b0000 ||
        u_if.remaining !== 8'd0) begin
      bad++;
      $display("FAIL stop_run: outs=%b rem=%0d, want 0000 0",
               {u_if.busy, u_if.warn, u_if.timeout, u_if.expired}, u_if.remaining);
    end
    u_if.start = 1'b1;
    u_if.stop  = 1'b1;
    step();
    u_if.start = 1'b0;
    u_if.stop  = 1'b0;
    total++;
    if (u_if.busy !== 1'b0 || u_if.remaining !== 8'd0) begin
      bad++;
      $display("FAIL start_stop_same: busy=%b rem=%0d, want 0 0", u_if.busy, u_if.remaining);
    end
    do_start();
    steps(12);
    do_start();
    total++;
    if (u_if.expired !== 1'b0 || u_if.remaining !== 8'd3 || u_if.busy !== 1'b1 ||
        u_if.timeout !== 1'b0) begin
      bad++;
      $display("FAIL start_in_expired: expired=%b rem=%0d busy=%b timeout=%b, want 0 3 1 0",
               u_if.expired, u_if.remaining, u_if.busy, u_if.timeout);
    end
    do_stop();
  endtask

  task automatic test_async_reset();
    do_start();
    steps(8);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({u_if.busy, u_if.warn, u_if.timeout, u_if.expired} !== 4'b0000 ||
        u_if.remaining !== 8'd0) begin
      bad++;
      $display("FAIL async_reset_warn: outs=%b rem=%0d, want 0000 0",
               {u_if.busy, u_if.warn, u_if.timeout, u_if.expired}, u_if.remaining);
    end
    steps(2);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      total++;
      if (u_if.timeout !== 1'b0 || u_if.busy !== 1'b0 || u_if.expired !== 1'b0) begin
        bad++;
        $display("FAIL post_reset_idle[%0d]: timeout=%b busy=%b expired=%b, want 0 0 0",
                 i, u_if.timeout, u_if.busy, u_if.expired);
      end
    end
  endtask

  task automatic test_warn_disabled();
    u_if2.start = 1'b1;
    step();
    u_if2.start = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      step();
      total++;
      if (u_if2.warn !== 1'b0) begin
        bad++;
        $display("FAIL nowarn_warn[%0d]: warn=%b, want 0", i, u_if2.warn);
      end
      if (i == 4) begin
        total++;
        if (u_if2.remaining !== 8'd1) begin
          bad++;
          $display("FAIL nowarn_edge4: rem=%0d, want 1", u_if2.remaining);
        end
      end
      if (i == 7) begin
        total++;
        if (u_if2.timeout !== 1'b0 || u_if2.busy !== 1'b1) begin
          bad++;
          $display("FAIL nowarn_edge7: timeout=%b busy=%b, want 0 1",
                   u_if2.timeout, u_if2.busy);
        end
      end
      if (i == 8) begin
        total++;
        if (u_if2.timeout !== 1'b1 || u_if2.expired !== 1'b1) begin
          bad++;
          $display("FAIL nowarn_edge8: timeout=%b expired=%b, want 1 1",
                   u_if2.timeout, u_if2.expired);
        end
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    {u_if.start, u_if.stop, u_if.kick, u_if.ack}     = 4'b0000;
    {u_if2.start, u_if2.stop, u_if2.kick, u_if2.ack} = 4'b0000;
    test_reset();
    test_nominal();
    test_kick();
    test_ignored();
    test_stop();
    test_async_reset();
    test_warn_disabled();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/session_timer.md
# session_timer

Parametrised inactivity/session timer for the ATM controller. It counts whole seconds from a 1-second prescaler and warns the user before the session expires. It signals expiry with a one-cycle pulse plus a sticky flag held until acknowledged. Any user activity (`kick`) restarts the countdown. It sits between the keypad/card front end and the main ATM FSM, which starts it at session begin and stops or acknowledges it.

## Interface

Parameters:
- `CLK_FREQ`, 1000000: clock cycles per second; legal values are 2 and above.
- `TIMEOUT_SEC`, 30: session length in seconds; range 1 to 2^`SEC_W`-1.
- `WARN_SEC`, 10: remaining-seconds threshold for `warn`. 0 disables warning. Must be less than `TIMEOUT_SEC`.
- `SEC_W`, 8: width of the seconds counter and of `remaining`.

Ports:
- `clk`  in  1  system clock. One clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin or restart the session countdown.
- `stop`  in  1  abort the countdown and return to IDLE.
- `kick`  in  1  user activity; reloads the countdown.
- `ack`  in  1  acknowledge expiry; clears `expired`.
- `remaining`  out  `SEC_W`  whole seconds left.
- `busy`  out  1  high in RUN or WARN.
- `warn`  out  1  level, high in WARN.
- `timeout`  out  1  one-cycle pulse on expiry.
- `expired`  out  1  sticky level; high in EXPIRED.

## Operation

- **Internal counters**
  - Prescaler `pre` has width $clog2(`CLK_FREQ`) and counts 0 to `CLK_FREQ`-1.
  - A "tick" is the cycle in which `pre` equals `CLK_FREQ`-1 in RUN or WARN. On a tick, `pre` wraps to 0 and `remaining` decrements by 1.
- **States:** IDLE, RUN, WARN, EXPIRED.
- **IDLE**
  - `pre`=0, `remaining`=0, all outputs low.
  - `start` moves to RUN, with `remaining`=`TIMEOUT_SEC` and `pre`=0.
- **RUN**
  - On a tick, `remaining` decrements.
  - If the new value equals `WARN_SEC` and `WARN_SEC`≠0, go to WARN.
  - If the new value is 0, go to EXPIRED.
  - Expiry takes precedence over warn. This case does not arise when the parameters are legal.
- **WARN**
  - Ticks decrement as in RUN.
  - When the new value is 0, go to EXPIRED.
- **EXPIRED**
  - `remaining`=0, `pre` held at 0, `expired`=1.
  - `timeout`=1 only on the first cycle after entry.
  - `ack` moves to IDLE.
- **`kick` and `start` while running**
  - In RUN or WARN, either one reloads `remaining`=`TIMEOUT_SEC`, sets `pre`=0, and moves to RUN (clearing `warn`).
- **Ignored inputs**
  - `kick` is ignored in IDLE and EXPIRED.
  - `ack` is ignored outside EXPIRED.
- **`start` in EXPIRED:** restarts directly to RUN with a reload; `expired` clears.
- **Priority per cycle:** `stop` > `start` > `kick` > `ack` > tick.
  - `stop` sends every state to IDLE.
  - A kick coinciding with a tick reloads; no decrement.
- **Arithmetic:** `remaining` never underflows. Decrement happens only in RUN/WARN, where `remaining`≥1.

## Timing

- **Reset:** while `rst_n`=0, immediately (asynchronously) state=IDLE, `pre`=0, `remaining`=0, and `busy`, `warn`, `timeout`, `expired` are all 0.
  - Reset asserted mid-countdown aborts with no `timeout` pulse.
- **Output registration:** all outputs are registered and derived from state/counters. There is no combinational input-to-output path.
- **Start:** `start` sampled high at edge E gives `busy`=1 and `remaining`=`TIMEOUT_SEC` after E.
- **Countdown:**
  - `remaining` = `TIMEOUT_SEC`-k after edge E+k·`CLK_FREQ`.
  - `warn` rises after edge E+(`TIMEOUT_SEC`-`WARN_SEC`)·`CLK_FREQ`.
- **Expiry:**
  - `timeout` pulses for exactly the one cycle after edge E+`TIMEOUT_SEC`·`CLK_FREQ`.
  - `expired` rises at that same edge; `busy` and `warn` fall at it.
- **Kick:** a kick at edge K restarts the same schedule with E replaced by K.
- **Ack:** `ack` at edge A gives `expired`=0 after A. An `ack` coincident with the `timeout` pulse cycle is honoured.

## Test plan

Use `CLK_FREQ`=4, `TIMEOUT_SEC`=3, `WARN_SEC`=1 unless stated.

- **Nominal countdown:** `start` at edge 0 -> `remaining` 3/2/1 after edges 0/4/8. `warn`=1 from edge 8. `timeout` is a 1-cycle pulse after edge 12. `expired` stays 1 and `busy`=0.
- **Kick:** `start` at 0, `kick` at edge 10 (in WARN, coincident with no tick) -> `warn` drops after 10, `remaining`=3. `timeout` after edge 22. A kick on tick edge 4 gives `remaining`=3, not 2.
- **Ignored inputs and ack:** in EXPIRED, `kick` -> no change. `ack` -> `expired`=0 next edge, state IDLE. `ack` in RUN -> no effect.
- **Stop and priority:** `stop` at edge 5 -> all outputs 0 after 5. `start`+`stop` in the same cycle from IDLE -> stays IDLE. `start` in EXPIRED -> `expired`=0, `remaining`=3, `busy`=1.
- **Asynchronous reset:** drop `rst_n` mid-cycle during WARN -> all outputs 0 before the next clock edge. No `timeout` pulse, and the block stays IDLE after release.
- **Warning disabled:** `WARN_SEC`=0 with `TIMEOUT_SEC`=2 -> `warn` never asserts; `timeout` after edge 8.
